// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit: forward-select codes and FSM states.
package hazard_unit_pkg;

  // Forward-select encodings for the Execute-stage operand muxes.
  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from ResultW
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from ALUResultM

  // Hazard-unit control states.
  typedef enum logic {
    RUN,
    MEMWAIT
  } state_t;

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Forward-select for one Execute source operand; Memory stage beats Writeback,
// and register 0 never forwards.
module fwd_sel
  import hazard_unit_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [ADDR_W-1:0] rd_w,
  input  logic              reg_write_w,
  output logic [1:0]        sel
);

  // Priority match: newest producer (M) first, then W, else register file.
  always_comb begin
    // NOTE: default assigned first so every path drives sel and no latch is inferred.
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use bubble, branch flush and
// a memory-wait stall FSM with a sticky timeout flag.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int WAIT_MAX = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Rs1D,
  input  logic [ADDR_W-1:0] Rs2D,
  input  logic [ADDR_W-1:0] Rs1E,
  input  logic [ADDR_W-1:0] Rs2E,
  input  logic [ADDR_W-1:0] RdE,
  input  logic              RegWriteE,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              mem_timeout
);

  // Counter is at least 8 bits and always wide enough to hold WAIT_MAX.
  localparam int CNT_W = ($clog2(WAIT_MAX + 1) > 8) ? $clog2(WAIT_MAX + 1) : 8;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

  state_t             state, state_next;
  logic [ADDR_W-1:0]  RdM, RdW;
  logic               RegWriteM, RegWriteW;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_inc;
  logic               mem_stall;
  logic               load_use;

  fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (ForwardAE)
  );

  fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (ForwardBE)
  );

  assign load_use     = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign wait_cnt_inc = (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + 1'b1;

  // Next state and stall/flush decode; a memory stall freezes everything and
  // suppresses flushes, otherwise a branch flush outranks the load-use bubble.
  always_comb begin
    state_next = state;
    mem_stall  = 1'b0;
    case (state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          mem_stall  = 1'b1;
          state_next = MEMWAIT;
        end
      end
      MEMWAIT: begin
        if (MemReadyM) state_next = RUN;
        else           mem_stall  = 1'b1;
      end
      default: state_next = RUN;
    endcase

    StallE = mem_stall;
    StallM = mem_stall;
    StallF = mem_stall || (load_use && !PCSrcE);
    StallD = mem_stall || (load_use && !PCSrcE);
    FlushD = !mem_stall && PCSrcE;
    FlushE = !mem_stall && (PCSrcE || load_use);
  end

  // State register, M/W destination tracking, wait counter and sticky timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      RdM         <= '0;
      RegWriteM   <= 1'b0;
      RdW         <= '0;
      RegWriteW   <= 1'b0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (!mem_stall) begin
        RdM       <= RdE;
        RegWriteM <= RegWriteE;
        RdW       <= RdM;
        RegWriteW <= RegWriteM;
      end
      if (state == RUN) begin
        if (state_next == MEMWAIT) wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt_inc;
        if (wait_cnt_inc == WAIT_LIM) mem_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, then random
// stimulus compared against a behavioural pipeline model.
module tb_hazard_unit;

  localparam int ADDR_W   = 5;
  localparam int WAIT_MAX = 4;

  logic              clock;
  logic              reset;
  logic [ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic              RegWriteE, LoadE, PCSrcE, MemReqM, MemReadyM;
  logic              StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              mem_timeout;

  hazard_unit #(.ADDR_W(ADDR_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clock       (clock),
    .reset       (reset),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .RegWriteE   (RegWriteE),
    .LoadE       (LoadE),
    .PCSrcE      (PCSrcE),
    .MemReqM     (MemReqM),
    .MemReadyM   (MemReadyM),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .mem_timeout (mem_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output vector layout: {StallF,StallD,StallE,StallM, FlushD,FlushE, FwdA, FwdB, timeout}
  typedef struct {
    logic [ADDR_W-1:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic              rw, ld, br, req, rdy, rst;
    logic [10:0]       exp;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Behavioural model: index 0 = Memory stage, 1 = Writeback stage.
  int m_rd[2];
  bit m_we[2];
  bit m_wait;
  int m_len;
  bit m_to;

  wire [10:0] dut_out = {StallF, StallD, StallE, StallM, FlushD, FlushE,
                         ForwardAE, ForwardBE, mem_timeout};

  function automatic vec_t mk(int rs1d, int rs2d, int rs1e, int rs2e, int rde,
                              bit rw, bit ld, bit br, bit req, bit rdy, bit rst,
                              logic [10:0] exp);
    vec_t v;
    v.rs1d = ADDR_W'(rs1d); v.rs2d = ADDR_W'(rs2d);
    v.rs1e = ADDR_W'(rs1e); v.rs2e = ADDR_W'(rs2e); v.rde = ADDR_W'(rde);
    v.rw = rw; v.ld = ld; v.br = br; v.req = req; v.rdy = rdy; v.rst = rst;
    v.exp = exp;
    return v;
  endfunction

  function automatic logic [1:0] m_fwd(int rs);
    if (rs != 0 && m_we[0] && m_rd[0] == rs) return 2'b10;
    if (rs != 0 && m_we[1] && m_rd[1] == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_stall(vec_t v);
    return m_wait ? !v.rdy : (v.req && !v.rdy);
  endfunction

  function automatic logic [10:0] model_out(vec_t v);
    bit st, lu, hold, fd, fe;
    st   = m_stall(v);
    lu   = v.ld && v.rde != 0 && (v.rde == v.rs1d || v.rde == v.rs2d);
    hold = st || (lu && !v.br);
    fd   = !st && v.br;
    fe   = !st && (v.br || lu);
    return {hold, hold, st, st, fd, fe, m_fwd(int'(v.rs1e)), m_fwd(int'(v.rs2e)), m_to};
  endfunction

  task automatic model_reset();
    m_rd[0] = 0; m_rd[1] = 0; m_we[0] = 0; m_we[1] = 0;
    m_wait = 0; m_len = 0; m_to = 0;
  endtask

  task automatic model_clock(vec_t v);
    bit st;
    if (v.rst) begin
      model_reset();
    end else begin
      st = m_stall(v);
      if (!st) begin
        m_rd[1] = m_rd[0]; m_we[1] = m_we[0];
        m_rd[0] = int'(v.rde); m_we[0] = v.rw;
      end
      if (m_wait) begin
        m_len = (m_len + 1 > WAIT_MAX) ? WAIT_MAX : m_len + 1;
        if (m_len == WAIT_MAX) m_to = 1;
        if (v.rdy) m_wait = 0;
      end else if (v.req && !v.rdy) begin
        m_wait = 1;
        m_len  = 0;
      end
    end
  endtask

  task automatic check(string name, logic [10:0] got, logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(vec_t v);
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
    RegWriteE = v.rw; LoadE = v.ld; PCSrcE = v.br;
    MemReqM = v.req; MemReadyM = v.rdy; reset = v.rst;
  endtask

  // Drive one cycle, compare mid-cycle, then advance the model with the edge.
  task automatic apply(vec_t v, bit use_table, string name);
    drive(v);
    #2;
    check(name, dut_out, use_table ? v.exp : model_out(v));
    @(posedge clock);
    model_clock(v);
    #1;
  endtask

  vec_t tbl[26];

  initial begin
    // Directed sequence; expected outputs are hand-derived.
    tbl[0]  = mk(0,0,0,0,0, 0,0,0,0,0,0, 11'b0000_00_00_00_0); // after reset
    tbl[1]  = mk(0,0,0,0,5, 1,0,0,0,0,0, 11'b0000_00_00_00_0); // write x5
    tbl[2]  = mk(0,0,5,0,6, 1,0,0,0,0,0, 11'b0000_00_10_00_0); // A from M
    tbl[3]  = mk(0,0,0,5,0, 0,0,0,0,0,0, 11'b0000_00_00_01_0); // B from W
    tbl[4]  = mk(0,0,0,0,7, 1,0,0,0,0,0, 11'b0000_00_00_00_0);
    tbl[5]  = mk(0,0,0,0,7, 1,0,0,0,0,0, 11'b0000_00_00_00_0);
    tbl[6]  = mk(0,0,7,0,0, 1,0,0,0,0,0, 11'b0000_00_10_00_0); // M beats W
    tbl[7]  = mk(0,0,0,0,0, 0,0,0,0,0,0, 11'b0000_00_00_00_0); // x0 never forwards
    tbl[8]  = mk(0,3,0,0,3, 1,1,0,0,0,0, 11'b1100_01_00_00_0); // load-use
    tbl[9]  = mk(0,3,0,0,0, 0,0,0,0,0,0, 11'b0000_00_00_00_0); // bubble done
    tbl[10] = mk(4,0,0,0,4, 1,1,1,0,0,0, 11'b0000_11_00_00_0); // flush wins
    tbl[11] = mk(2,0,4,0,2, 1,1,1,1,0,0, 11'b1111_00_10_00_0); // wait 1
    tbl[12] = mk(2,0,4,0,2, 1,1,1,1,0,0, 11'b1111_00_10_00_0); // wait 2
    tbl[13] = mk(2,0,4,0,2, 1,1,1,1,0,0, 11'b1111_00_10_00_0); // wait 3
    tbl[14] = mk(0,0,4,0,0, 0,0,0,1,1,0, 11'b0000_00_10_00_0); // release
    for (int i = 15; i < 20; i++)
      tbl[i] = mk(0,0,0,0,0, 0,0,0,1,0,0, 11'b1111_00_00_00_0); // 5-cycle wait
    tbl[20] = mk(0,0,0,0,0, 0,0,0,1,1,0, 11'b0000_00_00_00_1); // timeout visible
    tbl[21] = mk(0,0,0,0,0, 0,0,0,0,0,0, 11'b0000_00_00_00_1); // sticky
    tbl[22] = mk(0,0,0,0,0, 0,0,0,0,0,0, 11'b0000_00_00_00_1);
    tbl[23] = mk(0,0,0,0,0, 0,0,0,1,0,0, 11'b1111_00_00_00_1); // enter wait
    tbl[24] = mk(0,0,0,0,0, 0,0,0,1,0,1, 11'b1111_00_00_00_1); // reset in wait
    tbl[25] = mk(0,0,0,0,0, 0,0,0,0,0,0, 11'b0000_00_00_00_0); // back in RUN

    drive(mk(0,0,0,0,0, 0,0,0,0,0,1, 11'b0));
    repeat (2) @(posedge clock);
    model_reset();
    #1;

    for (int i = 0; i < 26; i++) apply(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Random phase against the model; small index range to provoke matches.
    for (int i = 0; i < 500; i++) begin
      vec_t v;
      v = mk($urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7),
             $urandom_range(0,7), $urandom_range(0,7),
             1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
             1'($urandom_range(0,3) == 0), 1'($urandom_range(0,2) == 0),
             1'($urandom_range(0,1)), 1'($urandom_range(0,99) == 0), 11'b0);
      apply(v, 1'b0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 5, the register-index width.
REQ-002 The module SHALL have parameter WAIT_MAX, default 64, the memory-wait cycle count that raises the timeout flag.
REQ-003 The module SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port Rs1D, input, ADDR_W, source register 1 of the instruction in Decode.
REQ-006 The module SHALL have port Rs2D, input, ADDR_W, source register 2 of the instruction in Decode.
REQ-007 The module SHALL have port Rs1E, input, ADDR_W, source register 1 of the instruction in Execute.
REQ-008 The module SHALL have port Rs2E, input, ADDR_W, source register 2 of the instruction in Execute.
REQ-009 The module SHALL have port RdE, input, ADDR_W, destination register of the instruction in Execute.
REQ-010 The module SHALL have port RegWriteE, input, 1, Execute instruction writes the register file.
REQ-011 The module SHALL have port LoadE, input, 1, Execute instruction is a load (result comes from memory).
REQ-012 The module SHALL have port PCSrcE, input, 1, taken branch or jump resolved in Execute.
REQ-013 The module SHALL have port MemReqM, input, 1, Memory-stage instruction accesses data memory.
REQ-014 The module SHALL have port MemReadyM, input, 1, data memory completes the access this cycle.
REQ-015 The module SHALL have ports StallF, StallD, StallE and StallM, each output, 1, hold the corresponding pipeline register.
REQ-016 The module SHALL have ports FlushD and FlushE, each output, 1, clear the corresponding pipeline register.
REQ-017 The module SHALL have ports ForwardAE and ForwardBE, each output, 2, select for the Execute forwarding muxes: 00 register file, 01 ResultW, 10 ALUResultM.
REQ-018 The module SHALL have port mem_timeout, output, 1, sticky flag set when a memory wait reaches WAIT_MAX cycles.

Function
REQ-019 The module SHALL track the Memory and Writeback stages internally as registers RdM, RegWriteM, RdW and RegWriteW, loaded from RdE/RegWriteE and RdM/RegWriteM each cycle while StallM is 0.
REQ-020 ForwardAE SHALL be 10 when RegWriteM=1, RdM≠0 and RdM=Rs1E; else 01 when RegWriteW=1, RdW≠0 and RdW=Rs1E; else 00. The M stage has priority over the W stage.
REQ-021 ForwardBE SHALL follow the rule of REQ-020 with Rs2E in place of Rs1E.
REQ-022 Register index 0 SHALL never produce forwarding or a load-use stall.
REQ-023 The load-use condition SHALL be LoadE=1, RdE≠0 and (RdE=Rs1D or RdE=Rs2D).
REQ-024 When the load-use condition holds in RUN, the module SHALL assert StallF=1, StallD=1 and FlushE=1 for exactly one cycle, giving a one-bubble penalty.
REQ-025 When PCSrcE=1 in RUN, the module SHALL assert FlushD=1 and FlushE=1; if the load-use condition holds in the same cycle, the flush wins and StallF and StallD SHALL be 0.
REQ-026 The FSM SHALL have two states, RUN and MEMWAIT.
REQ-027 From RUN, MemReqM=1 with MemReadyM=0 SHALL select MEMWAIT combinationally in that same cycle, with StallF, StallD, StallE and StallM all at 1 and both flushes at 0.
REQ-028 The module SHALL remain in MEMWAIT, with all four stalls at 1, until MemReadyM=1; in that cycle the stalls SHALL be released and the next state SHALL be RUN.
REQ-029 MEMWAIT SHALL override load-use and PCSrcE: no flush is issued while stalled; a branch pending in E is acted on in the first RUN cycle.
REQ-030 An 8-bit-or-wider wait counter SHALL clear on entry to MEMWAIT, increment each MEMWAIT cycle, and saturate at WAIT_MAX.
REQ-031 When the wait counter reaches WAIT_MAX, mem_timeout SHALL be set to 1 and held until reset; waiting SHALL continue.
REQ-032 Forward selects SHALL hold constant during MEMWAIT because the tracked M/W registers are frozen.

Reset
REQ-033 On reset=1 at a clock edge, the state SHALL become RUN, RdM/RdW/wait counter SHALL become 0, RegWriteM/RegWriteW SHALL become 0, and mem_timeout SHALL become 0.
REQ-034 Immediately after reset, all stall and flush outputs SHALL be 0 and ForwardAE=ForwardBE=00, provided the inputs request no hazard.
REQ-035 Reset asserted during MEMWAIT SHALL abort the wait and return the FSM to RUN at the next edge.

Structure
REQ-036 A shared package SHALL hold the forward-select constants FWD_RF=00, FWD_WB=01 and FWD_MEM=10, and the FSM state enumeration.
REQ-037 One sub-module, fwd_sel, SHALL compute a single 2-bit forward select and SHALL be instantiated twice, for A and B.

Verification
REQ-038 Back-to-back ALU writes with RdE=5, then Rs1E=5 the next cycle -> ForwardAE=10; one cycle later, with Rs2E=5 -> ForwardBE=01.
REQ-039 Same register in M and W (RdM=RdW=7) with Rs1E=7 -> ForwardAE=10; with RdM=0 and Rs1E=0 -> 00.
REQ-040 LoadE=1, RdE=3 and Rs2D=3 -> one cycle of StallF=StallD=FlushE=1, then all 0.
REQ-041 PCSrcE=1 together with the load-use condition -> FlushD=FlushE=1 and StallF=StallD=0.
REQ-042 MemReqM=1 with MemReadyM low for 3 cycles -> all four stalls high for 3 cycles, released in the MemReadyM cycle; with WAIT_MAX=4 and a 5-cycle wait -> mem_timeout=1, and it stays 1 after the wait ends.
REQ-043 Reset pulsed in the 2nd MEMWAIT cycle -> FSM returns to RUN with all outputs 0 on the next cycle.
